conv_window_3x3: RTL and testbench
==================================

Name: conv_window_3x3

Overview:
- Consumes the three aligned row taps produced by the line buffer stage and assembles a sliding 3x3 pixel window using per-row shift registers.
- Emits one registered window per valid column position, with a window-valid strobe and window coordinates.
- Sits between the line buffer and the systolic-array PE feeder. It drops the two left-edge columns of each row, where the window is not yet full.

Parameters:
- WIDTH, 8, pixel bit width.
- COL_NUM, 482, pixels per input row.
- ROW_NUM, 256, number of row-triplets delivered per frame (beats with valid_in per frame = ROW_NUM*COL_NUM).
- CNT_W, 11, width of internal column/row counters and coordinate outputs; must satisfy 2^CNT_W > max(COL_NUM, ROW_NUM).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  upstream beat strobe (line buffer flag); taps valid this cycle.
- row_top  in  WIDTH  oldest row tap (line buffer stage-2 output).
- row_mid  in  WIDTH  middle row tap (stage-1 output).
- row_bot  in  WIDTH  newest row tap (stage-0 output).
- win_00..win_22  out  WIDTH each (9 ports)  window pixels; win_rc, r = 0 top, c = 0 leftmost/oldest.
- win_valid  out  1  window outputs valid this cycle.
- win_col  out  CNT_W  output column index of the current window (0-based).
- win_row  out  CNT_W  output row index of the current window.
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Reset: all win_* = 0, win_valid = 0, win_col = 0, win_row = 0, frame_done = 0, internal shift registers = 0, c_cnt = 0, r_cnt = 0.
- Shift on valid_in = 1, for each row r: s[r][0] <= s[r][1], s[r][1] <= s[r][2], s[r][2] <= tap_r. With valid_in = 0, the shift registers hold.
- Window outputs are registered from the post-shift contents: win_r0 = old s[r][1], win_r1 = old s[r][2], win_r2 = incoming tap. Latency is 1 clk from the third column's beat to win_valid.
- c_cnt counts valid beats 0..COL_NUM-1 and wraps to 0 on a beat at COL_NUM-1.
- r_cnt increments on the wrap beat and wraps to 0 when r_cnt == ROW_NUM-1 at the same time.
- win_valid (registered) = valid_in && c_cnt >= 2. It is deasserted in any cycle without a qualifying beat; no holding of stale valids.
- win_col <= c_cnt-2 and win_row <= r_cnt, both updated only on qualifying beats.
- Per row, the number of windows is COL_NUM-2; per frame it is (COL_NUM-2)*ROW_NUM.
- Row boundary: the shift registers are not cleared at wrap. The first two beats of each new row only refill them (no win_valid), so no window straddles two rows.
- frame_done (registered) = qualifying beat with c_cnt == COL_NUM-1 && r_cnt == ROW_NUM-1. It is asserted in the same cycle as that window's win_valid.
- Gaps: valid_in may drop for any number of cycles mid-row; the window resumes correctly with no loss.
- No backpressure: the downstream must accept a window every cycle win_valid = 1.
- Reset mid-frame: everything returns to reset values immediately (async). The next beat is treated as column 0, row 0.

Optional Feature:
- Macro: CONV_WIN_STRIDE2_EN.
- Defined: stride 2 in both dimensions. A window is emitted only when c_cnt >= 2 && c_cnt[0] == 0 (i.e. (c_cnt-2) even) and r_cnt[0] == 0.
  - win_col = (c_cnt-2)>>1 and win_row = r_cnt>>1.
  - frame_done fires on the last emitted window: the largest even c_cnt and largest even r_cnt within range.
  - Shifting is unchanged (every beat shifts).
- Undefined: stride 1, exactly as in Behaviour.

Test Plan:
- Reset, then COL_NUM=6, ROW_NUM=2; feed taps top=10*r+c, mid=100+10*r+c, bot=200+10*r+c for 12 continuous beats -> 8 windows. First window is (row 0, col 0): win_00=0, win_02=2, win_12=102, win_22=202. win_col sequence is 0,1,2,3,0,1,2,3; frame_done pulses only with the 8th window.
- Same stimulus with valid_in dropped for 3 cycles after every beat -> identical window contents and coordinates, each win_valid exactly 1 cycle wide, and no win_valid during gaps.
- Row boundary: at the beats with c_cnt=0 and c_cnt=1 of row 1 -> win_valid=0. First row-1 window has win_00=10 and win_02=12, with no row-0 pixels.
- Assert rst_n=0 asynchronously after 7 beats, release it, and restart the frame -> outputs zero during reset. The first window appears on the 3rd post-reset beat with win_col=0, win_row=0.
- With CONV_WIN_STRIDE2_EN, COL_NUM=7, ROW_NUM=3, 21 beats -> windows at c_cnt 2,4,6 on rows 0 and 2 only (6 windows). win_col is 0,1,2; win_row is 0,1; frame_done pulses with the window at row 2, c_cnt=6.

Source files
------------

// File: rtl/conv_window_3x3.sv
// conv_window_3x3: builds a sliding 3x3 pixel window from three aligned
// row taps and emits one registered window per valid column position.
// Optional build macro CONV_WIN_STRIDE2_EN selects stride 2 in both
// dimensions; without it the window slides with stride 1.
module conv_window_3x3 #(
  parameter int WIDTH   = 8,
  parameter int COL_NUM = 482,
  parameter int ROW_NUM = 256,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] row_top,
  input  logic [WIDTH-1:0] row_mid,
  input  logic [WIDTH-1:0] row_bot,
  output logic [WIDTH-1:0] win_00,
  output logic [WIDTH-1:0] win_01,
  output logic [WIDTH-1:0] win_02,
  output logic [WIDTH-1:0] win_10,
  output logic [WIDTH-1:0] win_11,
  output logic [WIDTH-1:0] win_12,
  output logic [WIDTH-1:0] win_20,
  output logic [WIDTH-1:0] win_21,
  output logic [WIDTH-1:0] win_22,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_col,
  output logic [CNT_W-1:0] win_row,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] C_END = CNT_W'(COL_NUM - 1);
  localparam logic [CNT_W-1:0] R_END = CNT_W'(ROW_NUM - 1);
`ifdef CONV_WIN_STRIDE2_EN
  // last emitted window sits on the largest even column/row in range
  localparam logic [CNT_W-1:0] C_FD = CNT_W'(((COL_NUM - 1) / 2) * 2);
  localparam logic [CNT_W-1:0] R_FD = CNT_W'(((ROW_NUM - 1) / 2) * 2);
`else
  localparam logic [CNT_W-1:0] C_FD = C_END;
  localparam logic [CNT_W-1:0] R_FD = R_END;
`endif

  logic [CNT_W-1:0] c_cnt, r_cnt;
  logic             qual, last;
  logic [CNT_W-1:0] col_next, row_next;

  // qualifying-beat decode and coordinate mapping
  always_comb begin
    qual     = 1'b0;
    col_next = c_cnt - CNT_W'(2);
    row_next = r_cnt;
`ifdef CONV_WIN_STRIDE2_EN
    qual     = valid_in && (c_cnt >= CNT_W'(2)) && !c_cnt[0] && !r_cnt[0];
    col_next = (c_cnt - CNT_W'(2)) >> 1;
    row_next = r_cnt >> 1;
`else
    qual     = valid_in && (c_cnt >= CNT_W'(2));
`endif
    last = qual && (c_cnt == C_FD) && (r_cnt == R_FD);
  end

  // column/row position of the incoming beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt <= '0;
      r_cnt <= '0;
    end else if (valid_in) begin
      if (c_cnt == C_END) begin
        c_cnt <= '0;
        r_cnt <= (r_cnt == R_END) ? '0 : r_cnt + CNT_W'(1);
      end else begin
        c_cnt <= c_cnt + CNT_W'(1);
      end
    end
  end

  // per-row shift registers; post-shift contents are the window itself,
  // so they double as the registered window outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {win_00, win_01, win_02} <= '0;
      {win_10, win_11, win_12} <= '0;
      {win_20, win_21, win_22} <= '0;
    end else if (valid_in) begin
      {win_00, win_01, win_02} <= {win_01, win_02, row_top};
      {win_10, win_11, win_12} <= {win_11, win_12, row_mid};
      {win_20, win_21, win_22} <= {win_21, win_22, row_bot};
    end
  end

  // window strobe, coordinates and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= qual;
      frame_done <= last;
      if (qual) begin
        win_col <= col_next;
        win_row <= row_next;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_3x3.sv
// Self-checking bench for conv_window_3x3: table of beats with expected
// strobes, plus a queue of expected windows consumed as the DUT emits them.
module tb_conv_window_3x3;

  localparam int WIDTH = 8;
  localparam int CNT_W = 11;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int COLS = 7;
  localparam int ROWS = 3;
  localparam bit S2   = 1'b1;
`else
  localparam int COLS = 6;
  localparam int ROWS = 2;
  localparam bit S2   = 1'b0;
`endif
  localparam int C_FD = S2 ? ((COLS - 1) / 2) * 2 : COLS - 1;
  localparam int R_FD = S2 ? ((ROWS - 1) / 2) * 2 : ROWS - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [WIDTH-1:0] row_top = '0, row_mid = '0, row_bot = '0;
  logic [WIDTH-1:0] win_00, win_01, win_02, win_10, win_11, win_12;
  logic [WIDTH-1:0] win_20, win_21, win_22;
  logic             win_valid, frame_done;
  logic [CNT_W-1:0] win_col, win_row;
  logic [WIDTH-1:0] got [9];

  conv_window_3x3 #(.WIDTH(WIDTH), .COL_NUM(COLS), .ROW_NUM(ROWS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .win_00(win_00), .win_01(win_01), .win_02(win_02),
    .win_10(win_10), .win_11(win_11), .win_12(win_12),
    .win_20(win_20), .win_21(win_21), .win_22(win_22),
    .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign got[0] = win_00; assign got[1] = win_01; assign got[2] = win_02;
  assign got[3] = win_10; assign got[4] = win_11; assign got[5] = win_12;
  assign got[6] = win_20; assign got[7] = win_21; assign got[8] = win_22;

  typedef struct {
    int r; int c; int gap;
    bit exp_valid; int exp_col; int exp_row; bit exp_fd;
  } vec_t;

  typedef struct {
    int px [9];
    int col; int row; bit fd;
  } win_t;

  vec_t tbl [$];
  win_t sbq [$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int pix(input int rs, input int r, input int c);
    return rs * 100 + 10 * r + c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // fill the table for nbeats beats of a frame starting at column 0, row 0
  task automatic build(input int gap, input int nbeats);
    vec_t v;
    tbl.delete();
    for (int i = 0; i < nbeats; i++) begin
      v.r = (i / COLS) % ROWS;
      v.c = i % COLS;
      v.gap = gap;
      v.exp_valid = (v.c >= 2) && (!S2 || ((v.c % 2 == 0) && (v.r % 2 == 0)));
      v.exp_col = S2 ? (v.c - 2) / 2 : v.c - 2;
      v.exp_row = S2 ? v.r / 2 : v.r;
      v.exp_fd  = v.exp_valid && (v.c == C_FD) && (v.r == R_FD);
      tbl.push_back(v);
    end
  endtask

  task automatic apply_beat(input vec_t v);
    win_t w;
    valid_in = 1'b1;
    row_top  = WIDTH'(pix(0, v.r, v.c));
    row_mid  = WIDTH'(pix(1, v.r, v.c));
    row_bot  = WIDTH'(pix(2, v.r, v.c));
    if (v.exp_valid) begin
      for (int k = 0; k < 9; k++) w.px[k] = pix(k / 3, v.r, v.c - 2 + (k % 3));
      w.col = v.exp_col;
      w.row = v.exp_row;
      w.fd  = v.exp_fd;
      sbq.push_back(w);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk($sformatf("win_valid r%0d c%0d", v.r, v.c), int'(win_valid), int'(v.exp_valid));
    chk($sformatf("frame_done r%0d c%0d", v.r, v.c), int'(frame_done), int'(v.exp_fd));
    if (win_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_window: got window at r%0d c%0d expected none", v.r, v.c);
      end else begin
        w = sbq.pop_front();
        for (int k = 0; k < 9; k++)
          chk($sformatf("win_%0d%0d r%0d c%0d", k / 3, k % 3, v.r, v.c), int'(got[k]), w.px[k]);
        chk("win_col", int'(win_col), w.col);
        chk("win_row", int'(win_row), w.row);
      end
    end else if (sbq.size() > 0) begin
      w = sbq.pop_front();
    end
    repeat (v.gap) begin
      @(posedge clk); #1;
      chk("gap_win_valid", int'(win_valid), 0);
      chk("gap_frame_done", int'(frame_done), 0);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply_beat(tbl[i]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_win_col"}, int'(win_col), 0);
    chk({tag, "_win_row"}, int'(win_row), 0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_win_%0d%0d", tag, k / 3, k % 3), int'(got[k]), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // continuous frame
    build(0, COLS * ROWS);
    run_table();

    // same frame with 3-cycle gaps after every beat
    build(3, COLS * ROWS);
    run_table();

    // partial frame, asynchronous reset mid-cycle, then a fresh frame
    build(0, 7);
    run_table();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk); #1;
    check_zero("held_rst");
    rst_n = 1'b1;
    sbq.delete();
    build(0, COLS * ROWS);
    run_table();

    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
